// File: rtl/port_tx.sv
// ---------------------------------------------------------------------------
// port_tx -- output-side transmitter for one switch port.
//
// Queues packet words offered by the switch fabric in a DEPTH-word FIFO and
// presents them one at a time on data_op/valid_op. The downstream receiver
// can stall a presented word with suspend_op. A one-cycle idle gap follows
// every delivered word, so each word produces its own rising edge on
// valid_op. Words whose target field (bits [3:0]) is zero are discarded on
// entry and counted in drop_count.
//
// Word layout: {data[7:0], source[3:0], target[3:0]}
//
// Ports:
//   clk         in   1        rising-edge clock
//   reset       in   1        synchronous, active-high reset
//   in_valid    in   1        fabric offers in_data this cycle
//   in_data     in   DATA_W   packet word from the fabric
//   in_ready    out  1        FIFO can accept (combinational, 0 in reset)
//   data_op     out  DATA_W   registered output word
//   valid_op    out  1        registered, data_op is valid
//   suspend_op  in   1        downstream stall while a word is presented
//   fifo_level  out  AW+1     words queued, excluding the word being sent
//   tx_count    out  16       words delivered, wraps
//   drop_count  out  8        null-target words dropped, saturates
// ---------------------------------------------------------------------------
module port_tx #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        data_op,
  output logic                     valid_op,
  input  logic                     suspend_op,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [15:0]              tx_count,
  output logic [7:0]               drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_pop;
  logic                w_deliver;

  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [LW-1:0]       r_level;
  logic [DATA_W-1:0]   r_data_op;
  logic                r_valid_op;
  logic [15:0]         r_tx_count;
  logic [7:0]          r_drop_count;

  logic                w_full;
  logic                w_empty;
  logic                w_accept;
  logic                w_push;
  logic                w_drop;

  // Full is judged on the registered level only: a pop in the same cycle
  // does not open a slot until the next cycle.
  assign w_full   = (r_level == LW'(DEPTH));
  assign w_empty  = (r_level == '0);
  assign in_ready = !w_full && !reset;

  assign w_accept = in_valid && in_ready;
  assign w_drop   = w_accept && (in_data[3:0] == 4'h0);
  assign w_push   = w_accept && (in_data[3:0] != 4'h0);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: every clocked assignment is non-blocking so all registers update
    // from the same pre-edge values, independent of statement order.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // -------------------------------------------------------------------------
  // FSM: next state and control strobes
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a signal
    // unassigned and infers a latch.
    w_next    = r_state;
    w_pop     = 1'b0;
    w_deliver = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = S_SEND;
        end
      end
      S_SEND: begin
        // Stall holds the word; the first edge with suspend low delivers it.
        if (!suspend_op) begin
          w_deliver = 1'b1;
          w_next    = S_GAP;
        end
      end
      S_GAP: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = S_SEND;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FIFO storage
  // -------------------------------------------------------------------------
  // NOTE: the storage array has no reset; emptiness is tracked by r_level, so
  // stale contents are never read and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  // -------------------------------------------------------------------------
  // Pointers, level, output register and counters
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_data_op    <= '0;
      r_valid_op   <= 1'b0;
      r_tx_count   <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);

      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + AW'(1);
        r_data_op <= r_mem[r_rd_ptr];
      end

      // Simultaneous push and pop leave the level unchanged.
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase

      r_valid_op <= (w_next == S_SEND);

      if (w_deliver) r_tx_count <= r_tx_count + 16'd1;

      if (w_drop && (r_drop_count != 8'hFF)) r_drop_count <= r_drop_count + 8'd1;
    end
  end

  assign data_op    = r_data_op;
  assign valid_op   = r_valid_op;
  assign fifo_level = r_level;
  assign tx_count   = r_tx_count;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_port_tx.sv
// ---------------------------------------------------------------------------
// tb_port_tx -- self-checking bench for port_tx (DEPTH = 8, DATA_W = 16).
//
// Stimulus is issued from the main initial block with inputs changed 1 ns
// after each rising edge. Every accepted non-null word is pushed into an
// expected-word queue; an independent monitor samples outputs on the falling
// edge, pops the queue on each rising edge of valid_op and compares data_op.
// The monitor also checks that a presented word is held stable while valid_op
// stays high and that a delivered word is always followed by a low cycle.
// ---------------------------------------------------------------------------
module tb_port_tx;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 16;

  logic                   clk;
  logic                   reset;
  logic                   in_valid;
  logic [DATA_W-1:0]      in_data;
  logic                   in_ready;
  logic [DATA_W-1:0]      data_op;
  logic                   valid_op;
  logic                   suspend_op;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [15:0]            tx_count;
  logic [7:0]             drop_count;

  port_tx #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .data_op    (data_op),
    .valid_op   (valid_op),
    .suspend_op (suspend_op),
    .fifo_level (fifo_level),
    .tx_count   (tx_count),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned        n_checks = 0;
  int unsigned        n_fail   = 0;
  logic [DATA_W-1:0]  exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one word for one edge. exp_ready is the hand-derived acceptance.
  task automatic send_word(input logic [DATA_W-1:0] d, input logic exp_ready);
    in_valid = 1'b1;
    in_data  = d;
    check("in_ready", in_ready, exp_ready);
    if (exp_ready && (d[3:0] != 4'h0)) exp_q.push_back(d);
    tick(1);
    in_valid = 1'b0;
  endtask

  // Bounded wait for all expected words to be delivered.
  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !valid_op && fifo_level == '0) break;
      tick(1);
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_level", fifo_level, 0);
    check("drain_valid_low", valid_op, 1'b0);
  endtask

  // -------------------------------------------------------------------------
  // Monitor
  // -------------------------------------------------------------------------
  logic              prev_valid = 1'b0;
  logic              prev_susp  = 1'b0;
  logic [DATA_W-1:0] prev_data  = '0;

  always @(negedge clk) begin
    if (valid_op && !prev_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: got %0h, expected no word (t=%0t)", data_op, $time);
      end else begin
        check("tx_word", data_op, exp_q.pop_front());
      end
    end
    if (valid_op && prev_valid) check("hold_data", data_op, prev_data);
    if (prev_valid && !prev_susp) check("gap_after_delivery", valid_op, 1'b0);
    prev_valid = valid_op;
    prev_susp  = suspend_op;
    prev_data  = data_op;
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] w;

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    suspend_op = 1'b0;
    tick(2);

    // Reset state
    check("rst_valid", valid_op, 1'b0);
    check("rst_data", data_op, 16'h0000);
    check("rst_level", fifo_level, 0);
    check("rst_tx", tx_count, 0);
    check("rst_drop", drop_count, 0);
    check("rst_in_ready", in_ready, 1'b0);
    reset = 1'b0;
    #1;
    check("in_ready_after_rst", in_ready, 1'b1);
    tick(1);

    // Single word: written at edge N, presented after N+1 for one cycle.
    send_word(16'hA50F, 1'b1);
    check("single_latency_low", valid_op, 1'b0);
    check("single_level", fifo_level, 1);
    tick(1);
    check("single_valid", valid_op, 1'b1);
    check("single_data", data_op, 16'hA50F);
    check("single_level_popped", fifo_level, 0);
    tick(1);
    check("single_gap", valid_op, 1'b0);
    check("single_data_held", data_op, 16'hA50F);
    check("single_tx", tx_count, 1);
    tick(2);

    // Back-to-back writes.
    send_word(16'h1101, 1'b1);
    send_word(16'h2202, 1'b1);
    send_word(16'h3304, 1'b1);
    check("b2b_level", fifo_level, 2);
    wait_drain(20);
    check("b2b_tx", tx_count, 4);

    // Suspend: word stays presented for 6 cycles, delivered on release.
    send_word(16'hC308, 1'b1);
    suspend_op = 1'b1;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      check("susp_valid", valid_op, 1'b1);
      check("susp_data", data_op, 16'hC308);
      tick(1);
    end
    check("susp_valid_last", valid_op, 1'b1);
    check("susp_tx_held", tx_count, 4);
    suspend_op = 1'b0;
    tick(1);
    check("susp_delivered_low", valid_op, 1'b0);
    check("susp_tx", tx_count, 5);
    tick(2);

    // Fill under suspend: 9 words accepted (1 in SEND + 8 queued), 10th refused.
    suspend_op = 1'b1;
    for (int i = 0; i < 10; i++) begin
      w = 16'h4035 + 16'(i << 8);
      send_word(w, (i < 9) ? 1'b1 : 1'b0);
    end
    check("fill_level", fifo_level, 8);
    check("fill_in_ready", in_ready, 1'b0);
    check("fill_valid", valid_op, 1'b1);
    check("fill_data_first", data_op, 16'h4035);
    suspend_op = 1'b0;
    wait_drain(40);
    check("fill_tx", tx_count, 14);

    // Eight more words across the pointer wrap.
    for (int i = 0; i < 8; i++) begin
      w = 16'h80A6 + 16'(i << 8);
      send_word(w, 1'b1);
    end
    wait_drain(40);
    check("wrap_tx", tx_count, 22);

    // Null target: dropped, never presented, counter saturates.
    send_word(16'h7730, 1'b1);
    tick(3);
    check("null_valid", valid_op, 1'b0);
    check("null_drop", drop_count, 1);
    check("null_level", fifo_level, 0);
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1;
      in_data  = {8'(i), 8'h70};
      tick(1);
      if (i == 252) check("drop_pre_sat", drop_count, 8'hFE);
    end
    in_valid = 1'b0;
    tick(1);
    check("drop_sat", drop_count, 8'hFF);
    check("null_tx_unchanged", tx_count, 22);
    check("null_valid_after", valid_op, 1'b0);

    // Reset mid-SEND with 3 words queued.
    suspend_op = 1'b1;
    send_word(16'h1E11, 1'b1);
    send_word(16'h2E12, 1'b1);
    send_word(16'h3E13, 1'b1);
    send_word(16'h4E14, 1'b1);
    check("pre_rst_level", fifo_level, 3);
    check("pre_rst_valid", valid_op, 1'b1);
    check("pre_rst_data", data_op, 16'h1E11);
    tick(1);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    #1;
    check("rst_in_ready_low", in_ready, 1'b0);
    exp_q.delete();
    tick(1);
    check("mid_rst_valid", valid_op, 1'b0);
    check("mid_rst_data", data_op, 16'h0000);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_tx", tx_count, 0);
    check("mid_rst_drop", drop_count, 0);
    reset      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    suspend_op = 1'b0;
    tick(10);
    check("post_rst_tx", tx_count, 0);
    check("post_rst_valid", valid_op, 1'b0);
    send_word(16'h5A12, 1'b1);
    wait_drain(20);
    check("post_rst_tx_one", tx_count, 1);

    tick(2);
    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/port_tx.md
# port_tx

Output-side transmitter for one switch port. Queues 16-bit packet words handed over by the switch fabric and drives them onto the port's output channel (`data_op`/`valid_op`), honouring `suspend_op` back-pressure from the downstream receiver. Enforces a one-cycle idle gap between words so that every packet produces a distinct rising edge on `valid_op`. Four instances sit between the switch fabric and `port0`..`port3`.

## Interface
- `DEPTH`, 8: FIFO depth in words; power of 2, ≥ 2.
- `DATA_W`, 16: word width; word layout is `{data[7:0], source[3:0], target[3:0]}`.

Ports:
- `clk`  in  1  clock; all logic samples on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  fabric offers `in_data` this cycle.
- `in_data`  in  DATA_W  packet word from the fabric.
- `in_ready`  out  1  FIFO can accept; equals `!full`, combinational.
- `data_op`  out  DATA_W  registered output word.
- `valid_op`  out  1  registered; `data_op` is valid.
- `suspend_op`  in  1  downstream stall; when high, the current word is held.
- `fifo_level`  out  $clog2(DEPTH)+1  number of words queued, excluding the word in SEND.
- `tx_count`  out  16  words delivered; wraps at 16'hFFFF→0.
- `drop_count`  out  8  null-target words dropped; saturates at 8'hFF.

## Operation
- Accept: a write occurs on an edge where `in_valid && in_ready`.
  - If `in_data[3:0] == 4'h0`, the word is not queued and `drop_count` increments (saturating).
  - Otherwise the word is written at `wr_ptr` and `wr_ptr` increments, wrapping modulo DEPTH.
- `in_ready` is 0 whenever `fifo_level == DEPTH`, even if a pop occurs in the same cycle.
- A write and a pop in the same cycle are allowed when not full. In that case `fifo_level` is unchanged.
- FSM states: IDLE, SEND, GAP.
  - IDLE: `valid_op` = 0. If `fifo_level != 0`: load `data_op` ← `mem[rd_ptr]`, increment `rd_ptr`, decrement level, go to SEND.
  - SEND: `valid_op` = 1 and `data_op` held.
    - Edge with `suspend_op == 0`: word delivered. `tx_count` increments, `valid_op` ← 0, go to GAP.
    - Edge with `suspend_op == 1`: stay in SEND with all outputs unchanged.
  - GAP: `valid_op` = 0 for exactly one cycle. Next edge: if `fifo_level != 0`, load the next word and go to SEND; otherwise go to IDLE.
- `data_op` holds its last value while `valid_op` = 0. It is never X after reset.

## Timing
- Reset (edge with `reset` = 1): FSM → IDLE; `wr_ptr`, `rd_ptr`, `fifo_level`, `tx_count`, `drop_count` → 0; `valid_op` → 0; `data_op` → 0.
  - Mid-operation reset discards the queued words and the word in SEND. No word is counted.
  - Inputs are ignored while `reset` is high; `in_ready` = 0 while `reset` is high.
- Latency, empty queue: word written at edge N → `valid_op` = 1 after edge N+1.
- Throughput with no suspend: one word per 2 cycles (SEND, GAP alternating).
- Suspend raised while in SEND: the word stays presented indefinitely. Delivery happens on the first edge with `suspend_op` = 0.
- `suspend_op` in IDLE or GAP has no effect. Loading into SEND is never blocked.
- `fifo_level` decrements on the edge where a word is loaded into SEND, not on delivery.
- Pointer wrap: after DEPTH writes, `wr_ptr` returns to 0. Full/empty is distinguished by `fifo_level`.

## Test plan
- Single word: after reset, write 16'hA50F → `valid_op` rises 2 edges later with `data_op` = 16'hA50F and stays high 1 cycle; `tx_count` = 1.
- Back-to-back writes of 16'h1101, 16'h2202, 16'h3304 (suspend = 0) → three `valid_op` pulses of 1 cycle, each separated by 1 low cycle, in write order; `tx_count` = 3.
- Suspend: word 16'hC308 in SEND, hold `suspend_op` = 1 for 5 cycles → `valid_op`/`data_op` stable for 6 cycles; delivered on release; `tx_count` = 1.
- Fill/wrap (DEPTH = 8), `suspend_op` = 1: write 10 words → 1 in SEND + 8 queued, `in_ready` = 0, level 8. Release suspend → all 9 delivered in order, then accept 8 more across the pointer wrap.
- Null target: write 16'h7730 → not queued, `valid_op` stays 0, `drop_count` = 1. Drive 300 null words → `drop_count` saturates at 8'hFF.
- Reset mid-SEND with 3 words queued → next cycle `valid_op` = 0, `data_op` = 0, `fifo_level` = 0, counters 0; no stale words appear afterwards.
